// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared load encodings, ROM load FSM states and ROM sizing
package rv_mem_pkg;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_funct3_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT0 = 2'd1,
        WAIT1 = 2'd2,
        DONE  = 2'd3
    } rom_ld_state_e;

    localparam int ROM_SIZE_DEFAULT = 4096;
    localparam int ROM_ADDR_W       = $clog2(ROM_SIZE_DEFAULT);

    function automatic logic funct3_legal(input logic [2:0] f3);
        case (f3)
            LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // An access straddles when its bytes run past the end of the addressed word.
    function automatic logic is_straddle(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            LD_LH, LD_LHU: return off == 2'd3;
            LD_LW:         return off != 2'd0;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rom_load_align.sv
// rtl/rom_load_align.sv - selects the loaded bytes from a word pair and extends them
module rom_load_align
    import rv_mem_pkg::*;
(
    input  logic [31:0] hi_word,
    input  logic [31:0] lo_word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        straddle
);

    logic [63:0] pair_shifted;
    logic [31:0] bytes;

    always_comb begin
        pair_shifted = {hi_word, lo_word} >> {off, 3'b000};
        bytes        = pair_shifted[31:0];
        case (funct3)
            LD_LB:   data = {{24{bytes[7]}}, bytes[7:0]};
            LD_LH:   data = {{16{bytes[15]}}, bytes[15:0]};
            LD_LW:   data = bytes;
            LD_LBU:  data = {24'd0, bytes[7:0]};
            LD_LHU:  data = {16'd0, bytes[15:0]};
            default: data = 32'd0;
        endcase
        straddle = is_straddle(funct3, off);
    end

endmodule

// File: rtl/rom_load_unit.sv
// rtl/rom_load_unit.sv - memory-stage load initiator on the instruction ROM's second read port
module rom_load_unit
    import rv_mem_pkg::*;
#(
    parameter int ROM_SIZE         = ROM_SIZE_DEFAULT,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_funct3,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_valid,
    output logic [31:0] o_rd_data,
    output logic        o_fault,
    output logic        o_rom_p2_en,
    output logic [31:0] o_rom_p2_addr,
    input  logic [31:0] i_rom_p2_rd
);

    localparam logic [31:0] ADDR_MASK = 32'(ROM_SIZE - 1) & ~32'd3;

    rom_ld_state_e state;
    logic [1:0]    off_q;
    logic [2:0]    funct3_q;
    logic [31:0]   word_q;

    logic [31:0]   align_lo;
    logic [31:0]   align_hi;
    logic [31:0]   align_data;
    logic          align_straddle;
    logic          req_fault;

    // In WAIT1 the buffered first word is the low half and the live read the high half.
    assign align_lo = (state == WAIT1) ? word_q : i_rom_p2_rd;
    assign align_hi = (state == WAIT1) ? i_rom_p2_rd : 32'd0;

    rom_load_align u_align (
        .hi_word  (align_hi),
        .lo_word  (align_lo),
        .off      (off_q),
        .funct3   (funct3_q),
        .data     (align_data),
        .straddle (align_straddle)
    );

    assign req_fault = !funct3_legal(i_funct3)
                     || (is_straddle(i_funct3, i_addr[1:0]) && !ALLOW_MISALIGNED);

    assign o_stall = i_req && (state != DONE);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state         <= IDLE;
            off_q         <= 2'd0;
            funct3_q      <= 3'd0;
            word_q        <= 32'd0;
            o_valid       <= 1'b0;
            o_fault       <= 1'b0;
            o_rd_data     <= 32'd0;
            o_rom_p2_en   <= 1'b0;
            o_rom_p2_addr <= 32'd0;
        end else begin
            o_valid     <= 1'b0;
            o_fault     <= 1'b0;
            o_rom_p2_en <= 1'b0;
            if (i_flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_req) begin
                            off_q    <= i_addr[1:0];
                            funct3_q <= i_funct3;
                            if (req_fault) begin
                                o_valid   <= 1'b1;
                                o_fault   <= 1'b1;
                                o_rd_data <= 32'd0;
                                state     <= DONE;
                            end else begin
                                o_rom_p2_en   <= 1'b1;
                                o_rom_p2_addr <= i_addr & ADDR_MASK;
                                state         <= WAIT0;
                            end
                        end
                    end
                    WAIT0: begin
                        if (align_straddle) begin
                            word_q        <= i_rom_p2_rd;
                            o_rom_p2_en   <= 1'b1;
                            o_rom_p2_addr <= (o_rom_p2_addr + 32'd4) & ADDR_MASK;
                            state         <= WAIT1;
                        end else begin
                            o_rd_data <= align_data;
                            o_valid   <= 1'b1;
                            state     <= DONE;
                        end
                    end
                    WAIT1: begin
                        o_rd_data <= align_data;
                        o_valid   <= 1'b1;
                        state     <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_load_unit.sv
// tb/tb_rom_load_unit.sv - self-checking bench for rom_load_unit
module tb_rom_load_unit;

    localparam int RS = 4096;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          stalls;
        int          ens;
        logic [31:0] a0;
        logic [31:0] a1;
    } exp_t;

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [2:0]  f3;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        sel = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] mem [RS/4];

    logic        stall_a, valid_a, fault_a, en_a;
    logic        stall_b, valid_b, fault_b, en_b;
    logic [31:0] data_a, data_b, raddr_a, raddr_b, rd_a, rd_b;
    logic        req_a, req_b;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign req_a = req && !sel;
    assign req_b = req && sel;
    assign rd_a  = en_a ? mem[raddr_a[11:2]] : 32'hDEAD_BEEF;
    assign rd_b  = en_b ? mem[raddr_b[11:2]] : 32'hDEAD_BEEF;

    rom_load_unit #(.ROM_SIZE(RS), .ALLOW_MISALIGNED(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req_a), .i_addr(addr), .i_funct3(f3),
        .i_flush(flush), .o_stall(stall_a), .o_valid(valid_a), .o_rd_data(data_a),
        .o_fault(fault_a), .o_rom_p2_en(en_a), .o_rom_p2_addr(raddr_a), .i_rom_p2_rd(rd_a)
    );

    rom_load_unit #(.ROM_SIZE(RS), .ALLOW_MISALIGNED(1'b0)) dut_na (
        .i_clk(clk), .i_rst(rst), .i_req(req_b), .i_addr(addr), .i_funct3(f3),
        .i_flush(flush), .o_stall(stall_b), .o_valid(valid_b), .o_rd_data(data_b),
        .o_fault(fault_b), .o_rom_p2_en(en_b), .o_rom_p2_addr(raddr_b), .i_rom_p2_rd(rd_b)
    );

    wire        cur_stall = sel ? stall_b : stall_a;
    wire        cur_valid = sel ? valid_b : valid_a;
    wire        cur_fault = sel ? fault_b : fault_a;
    wire        cur_en    = sel ? en_b : en_a;
    wire [31:0] cur_data  = sel ? data_b : data_a;
    wire [31:0] cur_raddr = sel ? raddr_b : raddr_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[11:2]];
        return w[8*a[1:0] +: 8];
    endfunction

    // Reference: byte-level view of the ROM, sizes and wrap from plain arithmetic.
    function automatic exp_t model(input logic allow, input logic [31:0] a, input logic [2:0] f);
        exp_t        r;
        int          size;
        logic        legal, strad, sgn;
        logic [31:0] v;
        legal = (f == 3'b000) || (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b101);
        size  = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        strad = (int'(a[1:0]) + size) > 4;
        sgn   = !f[2];
        r.a0  = 32'(a % RS) & ~32'd3;
        r.a1  = (r.a0 + 32'd4) % RS;
        if (!legal || (strad && !allow)) begin
            r.data = 32'd0; r.fault = 1'b1; r.stalls = 1; r.ens = 0;
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++)
                v = v | (32'(rom_byte((a + 32'(i)) % RS)) << (8 * i));
            if (sgn && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (sgn && size == 2 && v[15]) v = v | 32'hFFFF_0000;
            r.data = v; r.fault = 1'b0; r.ens = strad ? 2 : 1; r.stalls = 1 + r.ens;
        end
        return r;
    endfunction

    // Called just after a rising edge; returns just after the edge that leaves DONE.
    task automatic run_load(input logic s, input logic [31:0] a, input logic [2:0] f,
                            input exp_t e, input string tag);
        int          stalls, ens;
        logic        got;
        logic [31:0] ea [2];
        logic [31:0] gd;
        logic        gf, gs;
        stalls = 0; ens = 0; got = 1'b0; gd = 32'd0; gf = 1'b0; gs = 1'b0;
        ea[0] = 32'hFFFF_FFFF; ea[1] = 32'hFFFF_FFFF;
        sel = s; req = 1'b1; addr = a; f3 = f;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (cur_en) begin
                if (ens < 2) ea[ens] = cur_raddr;
                ens++;
            end
            if (cur_valid) begin
                got = 1'b1; gd = cur_data; gf = cur_fault; gs = cur_stall;
            end else if (cur_stall) begin
                stalls++;
            end
        end
        @(posedge clk); #1;
        req = 1'b0;
        chk({tag, " valid"}, 32'(got), 32'd1);
        chk({tag, " data"}, gd, e.data);
        chk({tag, " fault"}, 32'(gf), 32'(e.fault));
        chk({tag, " stall_at_valid"}, 32'(gs), 32'd0);
        chk({tag, " stalls"}, 32'(stalls), 32'(e.stalls));
        chk({tag, " en_count"}, 32'(ens), 32'(e.ens));
        if (e.ens >= 1) chk({tag, " addr0"}, ea[0], e.a0);
        if (e.ens >= 2) chk({tag, " addr1"}, ea[1], e.a1);
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic flt, input int st,
                                input int en, input logic [31:0] a0, input logic [31:0] a1);
        exp_t r;
        r.data = d; r.fault = flt; r.stalls = st; r.ens = en; r.a0 = a0; r.a1 = a1;
        return r;
    endfunction

    initial begin
        vec_t        vecs [12];
        exp_t        e;
        logic [31:0] ra;
        logic [2:0]  rf;
        logic        rs, seen;
        logic [2:0]  f3_pool [8];

        for (int i = 0; i < RS / 4; i++) mem[i] = $urandom;
        mem[32'h100 >> 2] = 32'h80FF_7F01;
        mem[32'h104 >> 2] = 32'h1122_3344;
        mem[0]            = 32'hA1B2_C3D4;
        mem[RS/4 - 1]     = 32'h5566_7788;

        vecs[0]  = '{1'b0, 32'h100, 3'b010, mk(32'h80FF_7F01, 0, 2, 1, 32'h100, 0)};
        vecs[1]  = '{1'b0, 32'h103, 3'b000, mk(32'hFFFF_FF80, 0, 2, 1, 32'h100, 0)};
        vecs[2]  = '{1'b0, 32'h103, 3'b100, mk(32'h0000_0080, 0, 2, 1, 32'h100, 0)};
        vecs[3]  = '{1'b0, 32'h102, 3'b001, mk(32'hFFFF_80FF, 0, 2, 1, 32'h100, 0)};
        vecs[4]  = '{1'b0, 32'h100, 3'b101, mk(32'h0000_7F01, 0, 2, 1, 32'h100, 0)};
        vecs[5]  = '{1'b0, 32'h102, 3'b010, mk(32'h3344_80FF, 0, 3, 2, 32'h100, 32'h104)};
        vecs[6]  = '{1'b0, 32'h103, 3'b001, mk(32'h0000_4480, 0, 3, 2, 32'h100, 32'h104)};
        vecs[7]  = '{1'b0, 32'hFFE, 3'b010, mk(32'hC3D4_5566, 0, 3, 2, 32'hFFC, 32'h000)};
        vecs[8]  = '{1'b0, 32'h100, 3'b011, mk(32'h0000_0000, 1, 1, 0, 0, 0)};
        vecs[9]  = '{1'b1, 32'h102, 3'b010, mk(32'h0000_0000, 1, 1, 0, 0, 0)};
        vecs[10] = '{1'b1, 32'h100, 3'b010, mk(32'h80FF_7F01, 0, 2, 1, 32'h100, 0)};
        vecs[11] = '{1'b0, 32'h101, 3'b001, mk(32'hFFFF_FF7F, 0, 2, 1, 32'h100, 0)};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset valid", 32'(valid_a), 32'd0);
        chk("reset fault", 32'(fault_a), 32'd0);
        chk("reset en", 32'(en_a), 32'd0);
        chk("reset data", data_a, 32'd0);
        chk("reset rom_addr", raddr_a, 32'd0);
        chk("reset stall", 32'(stall_a), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 12; i++)
            run_load(vecs[i].sel, vecs[i].addr, vecs[i].f3, vecs[i].e, $sformatf("vec%0d", i));

        // Flush in WAIT1: the pending straddle result must never appear.
        run_load(1'b0, 32'h100, 3'b010, mk(32'h80FF_7F01, 0, 2, 1, 32'h100, 0), "pre_flush");
        req = 1'b1; addr = 32'h102; f3 = 3'b010;
        @(posedge clk); @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (valid_a || en_a) seen = 1'b1;
        end
        chk("flush_wait1 no_valid", 32'(seen), 32'd0);
        chk("flush_wait1 data_held", data_a, 32'h80FF_7F01);
        @(posedge clk); #1;
        run_load(1'b0, 32'h104, 3'b010, mk(32'h1122_3344, 0, 2, 1, 32'h104, 0), "post_flush");

        // Flush together with a request in IDLE issues nothing.
        req = 1'b1; flush = 1'b1; addr = 32'h100; f3 = 3'b010;
        @(posedge clk); #1;
        req = 1'b0; flush = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (valid_a || en_a) seen = 1'b1;
        end
        chk("flush_idle no_access", 32'(seen), 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a straddle.
        req = 1'b1; addr = 32'h102; f3 = 3'b010;
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset en", 32'(en_a), 32'd0);
        chk("midreset valid", 32'(valid_a), 32'd0);
        chk("midreset data", data_a, 32'd0);
        chk("midreset rom_addr", raddr_a, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Request dropped after acceptance still completes with a valid pulse.
        req = 1'b1; addr = 32'h103; f3 = 3'b000;
        @(posedge clk); #1;
        req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            if (valid_a) seen = 1'b1;
        end
        chk("req_drop valid", 32'(seen), 32'd1);
        chk("req_drop data", data_a, 32'hFFFF_FF80);
        @(posedge clk); #1;

        f3_pool = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b011, 3'b111};
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            if (i % 5 == 0) ra[11:2] = 10'h3FF;
            rf = f3_pool[$urandom_range(0, 7)];
            rs = ($urandom_range(0, 3) == 0);
            e  = model(!rs, ra, rf);
            run_load(rs, ra, rf, e, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
